coef_unpacker: RTL and testbench

Parametrised streaming unpacker that turns a stream of packed IN_W-bit words into a stream of N polynomial coefficients of D bits each, LSB-first. It handles D values that do not divide IN_W (e.g. D=12 over 32-bit words) with an internal bit buffer. It also applies the Kyber modulus reduction for D=12. It sits between the byte-oriented input path (ciphertext/key loads, PRF output) and the NTT/polynomial arithmetic core, and replaces the fixed 8-bit / 2-bit-per-coefficient converter.

---
 rtl/coef_unpacker_if.sv | 33 +++
 rtl/coef_unpacker.sv | 194 +++++++++++++++++++
 tb/tb_coef_unpacker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_unpacker_if.sv
// ----------------------------------------------------------------------------
// coef_unpacker_if
//
// Purpose: groups the two streaming handshakes of coef_unpacker.
//   Input side : packed words in_data / in_valid / in_ready.
//   Output side: coefficients coef_out / coef_valid / coef_ready / coef_last.
//
// Modports:
//   master - the environment: drives words and coef_ready, observes the rest.
//   slave  - the unpacker: accepts words, produces coefficients.
// ----------------------------------------------------------------------------
interface coef_unpacker_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 12
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] coef_out;
    logic             coef_valid;
    logic             coef_ready;
    logic             coef_last;

    modport master (
        output in_data, in_valid, coef_ready,
        input  in_ready, coef_out, coef_valid, coef_last
    );

    modport slave (
        input  in_data, in_valid, coef_ready,
        output in_ready, coef_out, coef_valid, coef_last
    );
endinterface

// File: rtl/coef_unpacker.sv
// ----------------------------------------------------------------------------
// coef_unpacker
//
// Purpose: streaming unpacker turning packed IN_W-bit words into N polynomial
// coefficients of G bits each, LSB-first. A bit buffer of IN_W+G-1 bits
// absorbs group widths that do not divide IN_W. With D = 12 each value is
// reduced once modulo Q (4095 < 2Q, so one conditional subtract suffices).
//
// Optional feature macro: KYBER_CBD_EN
//   defined   - adds port cbd_mode (sampled on start); when set, each group is
//               2*ETA bits and maps to the centered binomial value a-b mod Q.
//   undefined - plain mode only, no cbd_mode port, no popcount logic.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse: clear buffer and counter, begin a polynomial
//   cbd_mode    (KYBER_CBD_EN only) select CBD sampling for this polynomial
//   bus         coef_unpacker_if.slave: word input and coefficient output
//   busy        high while a polynomial is in progress
//   done        one-cycle pulse after the N-th coefficient handshake
// ----------------------------------------------------------------------------
module coef_unpacker #(
    parameter int IN_W  = 32,
    parameter int D     = 12,
    parameter int N     = 256,
    parameter int Q     = 3329,
    parameter int ETA   = 2,
    parameter int OUT_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef KYBER_CBD_EN
    input  logic            cbd_mode,
`endif
    coef_unpacker_if.slave  bus,
    output logic            busy,
    output logic            done
);

`ifdef KYBER_CBD_EN
    localparam int G_CBD = 2 * ETA;
    localparam int G_MAX = (D > G_CBD) ? D : G_CBD;
`else
    localparam int G_MAX = D;
`endif
    localparam int BUF_W = IN_W + G_MAX - 1;
    localparam int FW    = $clog2(BUF_W + 1);
    localparam int CW    = $clog2(N + 1);

    if (IN_W < 8 || IN_W > 64 || D < 1 || D > 12 || OUT_W < D ||
        ETA < 1 || N < 1) begin : g_param_err
        $error("coef_unpacker: illegal parameter set");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] bit_buf_p0;
    logic [FW-1:0]    fill_p0;
    logic [CW-1:0]    extracted_p0;
    logic [OUT_W-1:0] coef_p1;
    logic             coef_vld_p1;
    logic             coef_last_p1;
    logic             done_p1;

    logic [FW-1:0]    g_cur;
    logic [OUT_W-1:0] coef_d;
    logic             busy_c;
    logic             in_ready_c;
    logic             accept;
    logic             extract;
    logic             last_hs;

    // Plain-mode mapping: only the full 12-bit field can exceed Q.
    function automatic logic [OUT_W-1:0] map_plain(input logic [D-1:0] v);
        logic [OUT_W-1:0] w;
        w = OUT_W'(v);
        if (D == 12 && w >= OUT_W'(Q))
            w = w - OUT_W'(Q);
        return w;
    endfunction

`ifdef KYBER_CBD_EN
    logic cbd_q;

    // Centered binomial sample: popcount(low half) - popcount(high half),
    // folded into [0, Q) when negative.
    function automatic logic [OUT_W-1:0] map_cbd(input logic [G_CBD-1:0] v);
        int a;
        int b;
        a = 0;
        b = 0;
        for (int i = 0; i < ETA; i++) begin
            a += int'(v[i]);
            b += int'(v[ETA+i]);
        end
        if (a >= b)
            return OUT_W'(a - b);
        return OUT_W'(Q + a - b);
    endfunction

    assign g_cur  = cbd_q ? FW'(G_CBD) : FW'(D);
    assign coef_d = cbd_q ? map_cbd(bit_buf_p0[G_CBD-1:0])
                          : map_plain(bit_buf_p0[D-1:0]);
`else
    assign g_cur  = FW'(D);
    assign coef_d = map_plain(bit_buf_p0[D-1:0]);
`endif

    // Control: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and handshake decisions. in_ready is built from registers
    // only; accept (fill < G) and extract (fill >= G) can never coincide.
    always_comb begin
        state_d    = state_q;
        busy_c     = (state_q == RUN);
        in_ready_c = busy_c && (fill_p0 < g_cur) && (extracted_p0 < CW'(N));
        accept     = in_ready_c && bus.in_valid;
        extract    = busy_c && (fill_p0 >= g_cur) && (extracted_p0 < CW'(N)) &&
                     (!coef_vld_p1 || bus.coef_ready);
        last_hs    = busy_c && coef_vld_p1 && coef_last_p1 && bus.coef_ready;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!start && last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: buffer fill/extract and coefficient output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf_p0   <= '0;
            fill_p0      <= '0;
            extracted_p0 <= '0;
            coef_p1      <= '0;
            coef_vld_p1  <= 1'b0;
            coef_last_p1 <= 1'b0;
            done_p1      <= 1'b0;
`ifdef KYBER_CBD_EN
            cbd_q        <= 1'b0;
`endif
        end else if (start) begin
            // Abort/restart: anything pending is dropped.
            bit_buf_p0   <= '0;
            fill_p0      <= '0;
            extracted_p0 <= '0;
            coef_vld_p1  <= 1'b0;
            coef_last_p1 <= 1'b0;
            done_p1      <= 1'b0;
`ifdef KYBER_CBD_EN
            cbd_q        <= cbd_mode;
`endif
        end else begin
            done_p1 <= last_hs;

            if (last_hs) begin
                // Leftover bits past the N-th coefficient are discarded.
                bit_buf_p0 <= '0;
                fill_p0    <= '0;
            end else if (accept) begin
                bit_buf_p0 <= bit_buf_p0 | (BUF_W'(bus.in_data) << fill_p0);
                fill_p0    <= fill_p0 + FW'(IN_W);
            end else if (extract) begin
                bit_buf_p0 <= bit_buf_p0 >> g_cur;
                fill_p0    <= fill_p0 - g_cur;
            end

            if (extract) begin
                coef_p1      <= coef_d;
                coef_vld_p1  <= 1'b1;
                coef_last_p1 <= (extracted_p0 == CW'(N - 1));
                extracted_p0 <= extracted_p0 + CW'(1);
            end else if (coef_vld_p1 && bus.coef_ready) begin
                coef_vld_p1  <= 1'b0;
                coef_last_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.coef_out   = coef_p1;
    assign bus.coef_valid = coef_vld_p1;
    assign bus.coef_last  = coef_last_p1;
    assign busy           = busy_c;
    assign done           = done_p1;

endmodule

// File: tb/tb_coef_unpacker.sv
// ----------------------------------------------------------------------------
// tb_coef_unpacker
//
// Bench for coef_unpacker. dut_a: D=12, IN_W=32, N=256. dut_b: D=1, N=32.
// Expected coefficients come from a bit-stream model over the accepted words.
// ----------------------------------------------------------------------------
module tb_coef_unpacker;
    localparam int IN_W  = 32;
    localparam int D     = 12;
    localparam int N     = 256;
    localparam int Q     = 3329;
    localparam int ETA   = 2;
    localparam int OUT_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;
`ifdef KYBER_CBD_EN
    logic cbd_mode_a;
    logic cbd_mode_b;
`endif

    coef_unpacker_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_a ();
    coef_unpacker_if #(.IN_W(32),   .OUT_W(12))    bus_b ();

    coef_unpacker #(.IN_W(IN_W), .D(D), .N(N), .Q(Q), .ETA(ETA), .OUT_W(OUT_W)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
`ifdef KYBER_CBD_EN
        .cbd_mode (cbd_mode_a),
`endif
        .bus      (bus_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    coef_unpacker #(.IN_W(32), .D(1), .N(32), .Q(Q), .ETA(ETA), .OUT_W(12)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
`ifdef KYBER_CBD_EN
        .cbd_mode (cbd_mode_b),
`endif
        .bus      (bus_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] acc_words[$];   // words accepted by dut_a in this polynomial
    logic [31:0] dir_q[$];       // directed words fed first, random afterwards
    int          obs[$];         // coefficients observed on handshakes

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Coefficient k = bits [k*g +: g] of the concatenated word stream, mapped.
    function automatic int exp_coef(input int k, input bit cbd);
        int g, v, a, b, idx, w;
        g = cbd ? 2 * ETA : D;
        v = 0; a = 0; b = 0;
        for (int j = 0; j < g; j++) begin
            idx = k * g + j;
            w   = idx / IN_W;
            if (w >= acc_words.size()) return -1;
            v |= int'(acc_words[w][idx % IN_W]) << j;
        end
        if (cbd) begin
            for (int i = 0; i < ETA; i++) begin
                a += (v >> i) & 1;
                b += (v >> (ETA + i)) & 1;
            end
            return (a >= b) ? a - b : Q + a - b;
        end
        return (D == 12 && v >= Q) ? v - Q : v;
    endfunction

    // One full polynomial on dut_a with random valid/ready densities.
    task automatic run_poly(input string name, input int pv, input int pr,
                            input bit cbd, input int max_cyc);
        int hs, ext, fillm, g, idx, ndone;
        bit stall, exp_done, finished;
        logic [OUT_W-1:0] prev;
        g = cbd ? 2 * ETA : D;
        @(negedge clk);
        start_a = 1'b1;
`ifdef KYBER_CBD_EN
        cbd_mode_a = cbd;
`endif
        bus_a.in_valid   = 1'b0;
        bus_a.coef_ready = 1'b0;
        acc_words.delete();
        obs.delete();
        @(negedge clk);
        start_a = 1'b0;
        check({name, ":busy_start"}, 64'(busy_a), 64'd1);
        check({name, ":vld_start"}, 64'(bus_a.coef_valid), 64'd0);
        hs = 0; stall = 0; exp_done = 0; finished = 0; prev = '0; ndone = 0;
        for (int cyc = 0; cyc < max_cyc && !finished; cyc++) begin
            if (exp_done) begin
                check({name, ":done"}, 64'(done_a), 64'd1);
                check({name, ":busy_end"}, 64'(busy_a), 64'd0);
                check({name, ":rdy_end"}, 64'(bus_a.in_ready), 64'd0);
                ndone += int'(done_a);
                finished = 1;
            end else begin
                check({name, ":done_low"}, 64'(done_a), 64'd0);
                if (stall) begin
                    check({name, ":hold_vld"}, 64'(bus_a.coef_valid), 64'd1);
                    check({name, ":hold_data"}, 64'(bus_a.coef_out), 64'(prev));
                end
                ext   = hs + int'(bus_a.coef_valid);
                fillm = acc_words.size() * IN_W - ext * g;
                check({name, ":in_ready"}, 64'(bus_a.in_ready), 64'(fillm < g && ext < N));
                if (bus_a.coef_valid)
                    check({name, ":last"}, 64'(bus_a.coef_last), 64'(hs == N - 1));
                idx = acc_words.size();
                bus_a.in_valid   = ($urandom % 100) < pv;
                bus_a.in_data    = (idx < dir_q.size()) ? dir_q[idx] : $urandom;
                bus_a.coef_ready = ($urandom % 100) < pr;
                #1;
                if (bus_a.in_valid && bus_a.in_ready)
                    acc_words.push_back(bus_a.in_data);
                if (bus_a.coef_valid && bus_a.coef_ready) begin
                    obs.push_back(int'(bus_a.coef_out));
                    check({name, ":coef"}, 64'(bus_a.coef_out), 64'(exp_coef(hs, cbd)));
                    hs++;
                    if (hs == N) exp_done = 1;
                end
                stall = bus_a.coef_valid && !bus_a.coef_ready;
                prev  = bus_a.coef_out;
                @(negedge clk);
            end
        end
        if (!finished) check({name, ":timeout"}, 64'd0, 64'd1);
        bus_a.in_valid = 1'b1;
        check({name, ":n_coef"}, 64'(hs), 64'(N));
        check({name, ":n_words"}, 64'(acc_words.size()), 64'((N * g + IN_W - 1) / IN_W));
        @(negedge clk);
        ndone += int'(done_a);
        check({name, ":done_once"}, 64'(ndone), 64'd1);
        check({name, ":rdy_idle"}, 64'(bus_a.in_ready), 64'd0);
        bus_a.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w5;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
`ifdef KYBER_CBD_EN
        cbd_mode_a = 1'b0; cbd_mode_b = 1'b0;
`endif
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.coef_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.coef_ready = 1'b0;
        #1;
        check("rst:in_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst:coef_out", 64'(bus_a.coef_out), 64'd0);
        check("rst:coef_valid", 64'(bus_a.coef_valid), 64'd0);
        check("rst:coef_last", 64'(bus_a.coef_last), 64'd0);
        check("rst:busy", 64'(busy_a), 64'd0);
        check("rst:done", 64'(done_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // D=1: one word 0x5 yields 32 single-bit coefficients back-to-back.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        check("d1:rdy", 64'(bus_b.in_ready), 64'd1);
        bus_b.in_valid = 1'b1; bus_b.in_data = 32'h0000_0005; bus_b.coef_ready = 1'b1;
        @(negedge clk); bus_b.in_valid = 1'b0;
        check("d1:latency", 64'(bus_b.coef_valid), 64'd0);
        w5 = 32'h0000_0005;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("d1:vld", 64'(bus_b.coef_valid), 64'd1);
            check("d1:coef", 64'(bus_b.coef_out), 64'(w5[k]));
            check("d1:last", 64'(bus_b.coef_last), 64'(k == 31));
        end
        @(negedge clk);
        check("d1:done", 64'(done_b), 64'd1);
        check("d1:busy", 64'(busy_b), 64'd0);
        @(negedge clk);
        check("d1:done_off", 64'(done_b), 64'd0);
        bus_b.coef_ready = 1'b0;

        // D=12 directed head of stream, then random words, full speed.
        dir_q = '{32'h00F0_0ABC, 32'h0000_0123};
        run_poly("dir", 100, 100, 1'b0, 3000);
        check("dir:c0", 64'(obs[0]), 64'd2748);
        check("dir:c1", 64'(obs[1]), 64'd511);
        check("dir:c2", 64'(obs[2]), 64'd768);
        dir_q.delete();
        run_poly("rnd", 70, 60, 1'b0, 5000);
        run_poly("bp", 80, 20, 1'b0, 8000);

        // Asynchronous reset with coef_valid=1 and 8 bits left in the buffer.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = 32'h00F0_0ABC; bus_a.coef_ready = 1'b0;
        @(negedge clk); bus_a.in_valid = 1'b0;
        @(negedge clk);
        check("mr:c0", 64'(bus_a.coef_out), 64'd2748);
        check("mr:vld0", 64'(bus_a.coef_valid), 64'd1);
        bus_a.coef_ready = 1'b1;
        @(negedge clk);
        check("mr:c1", 64'(bus_a.coef_out), 64'd511);
        check("mr:rdy_fill8", 64'(bus_a.in_ready), 64'd1);
        bus_a.coef_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mr:in_ready", 64'(bus_a.in_ready), 64'd0);
        check("mr:coef_out", 64'(bus_a.coef_out), 64'd0);
        check("mr:coef_valid", 64'(bus_a.coef_valid), 64'd0);
        check("mr:coef_last", 64'(bus_a.coef_last), 64'd0);
        check("mr:busy", 64'(busy_a), 64'd0);
        check("mr:done", 64'(done_a), 64'd0);
        @(negedge clk); rst_n = 1'b1; bus_a.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mr:idle_busy", 64'(busy_a), 64'd0);
            check("mr:idle_rdy", 64'(bus_a.in_ready), 64'd0);
            check("mr:idle_vld", 64'(bus_a.coef_valid), 64'd0);
        end
        bus_a.in_valid = 1'b0;

        // start while RUN drops the pending coefficient and restarts.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = $urandom;
        @(negedge clk); bus_a.in_valid = 1'b0;
        @(negedge clk);
        check("ab:vld_before", 64'(bus_a.coef_valid), 64'd1);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("ab:vld_after", 64'(bus_a.coef_valid), 64'd0);
        check("ab:busy", 64'(busy_a), 64'd1);
        check("ab:rdy", 64'(bus_a.in_ready), 64'd1);
        run_poly("post_abort", 90, 90, 1'b0, 3000);

`ifdef KYBER_CBD_EN
        dir_q = '{32'h0000_00C7};
        run_poly("cbd", 90, 80, 1'b1, 3000);
        check("cbd:c0", 64'(obs[0]), 64'd1);
        check("cbd:c1", 64'(obs[1]), 64'd3327);
        dir_q.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
